// File: rtl/pll_reset_pkg.sv
// rtl/pll_reset_pkg.sv - shared types, constants and helpers for the PLL reset sequencer
package pll_reset_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } seq_state_t;

   localparam int LOSS_CNT_W = 8;

   // Bits needed for a counter that runs 0 .. max(a,b)-1; never narrower than one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_lock_sync.sv
// rtl/pll_reset_sequencer_lock_sync.sv - multi-flop synchroniser bringing the PLL lock flag into the clock domain
module lock_sync #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] chain;

   // Shift the asynchronous input through the chain; cleared to 0 on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
      end
   end

   assign dout = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - qualifies PLL lock and sequences downstream reset release (macro PLL_RESET_SEQ_LOSS_COUNTER_EN enables the lock-loss counter)
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  locked,
   output logic                  reset_out,
   output logic                  ready,
   output logic [LOSS_CNT_W-1:0] lock_lost_count
);

   localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

   logic       locked_s;
   seq_state_t state;
   logic [CNT_W-1:0] cnt;

   lock_sync #(
      .STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clock(clock),
      .reset(reset),
      .din  (locked),
      .dout (locked_s)
   );

   // Lock qualification FSM; reset_out/ready are loaded with the value implied by the state being entered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= WAIT_LOCK;
         cnt       <= '0;
         reset_out <= 1'b1;
         ready     <= 1'b0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               if (locked_s) begin
                  state <= STABLE;
                  cnt   <= '0;
               end
            end
            STABLE: begin
               if (!locked_s) begin
                  state <= WAIT_LOCK;
               end else if (cnt == STABLE_LAST) begin
                  state <= HOLD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!locked_s) begin
                  state <= WAIT_LOCK;
               end else if (cnt == HOLD_LAST) begin
                  state     <= RUN;
                  reset_out <= 1'b0;
                  ready     <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (!locked_s) begin
                  state     <= WAIT_LOCK;
                  reset_out <= 1'b1;
                  ready     <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
   logic [LOSS_CNT_W-1:0] loss_q;

   // Count lock drops seen while running, saturating at all-ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         loss_q <= '0;
      end else if ((state == RUN) && !locked_s && (loss_q != '1)) begin
         loss_q <= loss_q + 1'b1;
      end
   end

   assign lock_lost_count = loss_q;
`else
   assign lock_lost_count = '0;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops synchronising locked into the clock domain; legal values are 2 or more.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive cycles synchronised lock must stay high before reset release begins; legal values are 1 or more.
REQ-003 Parameter RESET_HOLD_CYCLES, default 16: number of cycles reset_out stays asserted after lock is qualified; legal values are 1 or more.
REQ-004 clock  input  1  PLL output clock (clock_out of the PLL wrapper); the single clock of the block.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 locked  input  1  PLL lock flag, asynchronous to clock.
REQ-007 reset_out  output  1  active-high reset to downstream logic; asserts asynchronously and deasserts synchronously to clock.
REQ-008 ready  output  1  high only in state RUN; registered.
REQ-009 lock_lost_count  output  8  saturating count of lock losses seen while in RUN.

Function
REQ-010 locked passes through SYNC_STAGES flops to give locked_s; all FSM decisions use only locked_s.
REQ-011 The FSM states are WAIT_LOCK, STABLE, HOLD and RUN, with one shared counter cnt.
REQ-012 WAIT_LOCK: when locked_s=1, go to STABLE with cnt=0; otherwise stay.
REQ-013 STABLE: when locked_s=0, go to WAIT_LOCK; when cnt==LOCK_STABLE_CYCLES-1, go to HOLD with cnt=0; otherwise increment cnt.
REQ-014 HOLD: when locked_s=0, go to WAIT_LOCK; when cnt==RESET_HOLD_CYCLES-1, go to RUN; otherwise increment cnt.
REQ-015 RUN: when locked_s=0, go to WAIT_LOCK and increment lock_lost_count on the same edge; lock_lost_count saturates at 255 and never wraps.
REQ-016 reset_out and ready are registered from next-state: reset_out = (next!=RUN) and ready = (next==RUN); reset_out therefore asserts on the same edge the FSM leaves RUN.
REQ-017 Latency: counting the first edge that samples locked=1 as edge 1, reset_out falls at edge SYNC_STAGES+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES+1, provided locked stays high throughout.
REQ-018 Any drop of locked_s before RUN restarts qualification from WAIT_LOCK and does not change lock_lost_count.
REQ-019 cnt width is the width needed for max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES); cnt never wraps.

Reset
REQ-020 On reset=1, immediately and without a clock edge: state=WAIT_LOCK, cnt=0, all sync flops=0, reset_out=1, ready=0, lock_lost_count=0.
REQ-021 If reset is asserted mid-operation, including in the same cycle as a lock loss in RUN, reset wins and lock_lost_count is cleared.
REQ-022 After reset is released, qualification starts from WAIT_LOCK even if locked is already high.

Configuration
REQ-023 Macro PLL_RESET_SEQ_LOSS_COUNTER_EN defined: lock_lost_count is implemented as described in REQ-015.
REQ-024 Macro PLL_RESET_SEQ_LOSS_COUNTER_EN undefined: lock_lost_count is tied to 0, no counter flops exist, and all other behaviour is identical.

Structure
REQ-025 Shared package pll_reset_pkg holds the FSM state typedef (2-bit encoding), the lock-loss counter width constant (8), and the counter-width helper function.
REQ-026 Sub-module lock_sync holds the parameterised SYNC_STAGES flop chain with async reset to 0; it is instantiated once for locked.

Verification
REQ-027 Test bench parameters are SYNC_STAGES=2, LOCK_STABLE_CYCLES=8 and RESET_HOLD_CYCLES=4.
REQ-028 Reset, then locked=1 held -> reset_out falls and ready rises at edge 15; lock_lost_count=0.
REQ-029 locked high for 5 cycles, low for 3, then high -> no release before 15 edges counted from the final rise.
REQ-030 In RUN, locked low for 1 cycle -> reset_out=1 two edges later, ready=0, lock_lost_count=1; re-release occurs 15 edges after locked returns.
REQ-031 260 lock losses from RUN -> lock_lost_count=255 and holds there; with the macro undefined it stays 0 throughout.
REQ-032 reset pulsed mid-HOLD without a clock edge -> reset_out=1 and lock_lost_count=0 immediately; release occurs a full 15 edges after reset falls with locked high.
